btn_onehot_gen: RTL and testbench
=================================

BTN_ONEHOT_GEN -- requirements
Module: btn_onehot_gen

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CNT, default 4, number of consecutive stable cycles to accept a level change (legal range 1..255).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 btn  input  4  raw asynchronous push-button levels, 1 = pressed.
REQ-006 clr  input  1  synchronous request to drop the held code.
REQ-007 onehot  output  4  registered one-hot code, drives encoder input a[3:0].
REQ-008 en  output  1  registered active-low enable to the encoder: 0 = code valid, 1 = disabled.
REQ-009 valid  output  1  one-cycle pulse when onehot takes a new value.
REQ-010 err  output  1  one-cycle pulse when two or more press events occur in the same cycle.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL keep a debounced level and a counter of width clog2(DEBOUNCE_CNT+1).
- Counter clears on any edge where the synchronized bit equals the debounced level.
- Otherwise the counter increments.
- The debounced level flips on the edge where the counter would reach DEBOUNCE_CNT; the counter clears on that edge.
REQ-013 A press event SHALL be a 0->1 transition of a debounced level, detected by a registered copy of it; release events SHALL be ignored.
REQ-014 The control FSM SHALL have two states, IDLE and HOLD.
REQ-015 In IDLE with exactly one press event, on the next edge:
- onehot <= that channel's bit
- en <= 0
- valid pulses
- state <= HOLD
REQ-016 In HOLD with exactly one press event, on the next edge:
- onehot <= the new channel's bit, even if it is the same channel
- en stays 0
- valid pulses
REQ-017 In either state with two or more simultaneous press events, the block SHALL pulse err and leave onehot, en and state unchanged.
REQ-018 clr in HOLD SHALL give onehot=4'b0000, en=1, state IDLE on the next edge, with no valid pulse; clr in IDLE has no effect.
REQ-019 clr SHALL take priority over any coincident press event, and no valid or err pulse is produced in that cycle.
REQ-020 onehot SHALL always be 4'b0000 or exactly one bit set; en SHALL be 0 if and only if onehot is nonzero.
REQ-021 Latency: a btn level held constant from before clock edge k SHALL produce valid high in the cycle after edge k+DEBOUNCE_CNT+3, provided no other channel produces a press event in the same cycle.
REQ-022 Bounce shorter than DEBOUNCE_CNT synchronized cycles SHALL produce no press event.

Reset
REQ-023 On rst at a rising edge, all of the following SHALL be set:
- onehot=4'b0000, en=1, valid=0, err=0
- state IDLE
- synchronizers, debounced levels, edge registers and counters = 0
REQ-024 rst SHALL override clr and press events in the same cycle.
REQ-025 rst asserted mid-debounce SHALL discard the partial count; a button still held after reset SHALL be re-debounced from zero and yield one press event.

Verification (DEBOUNCE_CNT=4)
REQ-026 The bench SHALL cover these directed scenarios:
- Reset then btn=4'b0010 from edge 10 -> valid high for 1 cycle after edge 17; onehot=4'b0010; en=0.
- In HOLD with onehot=0010, press btn[3] -> onehot=4'b1000, valid pulse, en stays 0; then release btn[3] -> no change.
- btn[0] toggles every 2 cycles for 20 cycles, then settles to 0 -> no valid, onehot unchanged.
- btn[1] and btn[2] rise in the same cycle -> err single pulse, no valid, onehot and en unchanged.
- clr in the same cycle as a single press event in HOLD -> onehot=4'b0000, en=1, no valid, no err.
- rst at edge 14 while btn=4'b0100 is held and debouncing -> all outputs at reset values; single valid with onehot=4'b0100 seven edges after rst deasserts.

Source files
------------

// File: rtl/btn_onehot_gen.sv
`default_nettype none
// ============================================================================
//  Module   : btn_onehot_gen
//  Brief    : Four push-buttons are synchronized, debounced and edge-detected.
//             The result is held as a one-hot code with an active-low enable
//             for a downstream priority encoder.
//  Revision : 1.0  initial release
// ============================================================================
module btn_onehot_gen #(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       clr,
    output logic [3:0] onehot,
    output logic       en,
    output logic       valid,
    output logic       err
);

    localparam int               c_NCH  = 4;
    localparam int               c_CW   = $clog2(DEBOUNCE_CNT + 1);
    // The counter value seen on the edge where the next increment would reach DEBOUNCE_CNT
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [c_NCH-1:0] r_sync1;
    logic [c_NCH-1:0] r_sync2;
    logic [c_NCH-1:0] w_deb;
    logic [c_NCH-1:0] r_deb_d;
    logic [c_NCH-1:0] r_press;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_NCH-1:0] r_onehot;
    logic [c_NCH-1:0] w_onehot_nxt;
    logic             r_en;
    logic             w_en_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_any_press;
    logic             w_single_press;
    logic             w_multi_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar g = 0; g < c_NCH; g++) begin : g_chan
            logic [c_CW-1:0] r_cnt;
            logic            r_deb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2[g] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_LAST) begin
                    r_cnt <= '0;
                    r_deb <= ~r_deb;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb[g] = r_deb;
        end
    endgenerate

    // Press events are registered so the FSM only ever sees clean one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_d <= '0;
            r_press <= '0;
        end else begin
            r_deb_d <= w_deb;
            r_press <= w_deb & ~r_deb_d;
        end
    end

    assign w_any_press    = (r_press != 4'd0);
    assign w_single_press = w_any_press && ((r_press & (r_press - 4'd1)) == 4'd0);
    assign w_multi_press  = w_any_press && !w_single_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_onehot <= '0;
            r_en     <= 1'b1;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_onehot <= w_onehot_nxt;
            r_en     <= w_en_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // clr masks any coincident press event in both states
    always_comb begin
        w_state_nxt  = r_state;
        w_onehot_nxt = r_onehot;
        w_en_nxt     = r_en;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        if (clr) begin
            if (r_state == S_HOLD) begin
                w_state_nxt  = S_IDLE;
                w_onehot_nxt = '0;
                w_en_nxt     = 1'b1;
            end
        end else if (w_multi_press) begin
            w_err_nxt = 1'b1;
        end else if (w_single_press) begin
            w_state_nxt  = S_HOLD;
            w_onehot_nxt = r_press;
            w_en_nxt     = 1'b0;
            w_valid_nxt  = 1'b1;
        end
    end

    assign onehot = r_onehot;
    assign en     = r_en;
    assign valid  = r_valid;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_btn_onehot_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_onehot_gen
//  Brief    : Self-checking bench for btn_onehot_gen: vector table, directed
//             corner sequences and randomized traffic against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_onehot_gen;

    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       clr;
    logic [3:0] onehot;
    logic       en;
    logic       valid;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int vcount   = 0;
    int ecount   = 0;

    btn_onehot_gen #(
        .DEBOUNCE_CNT(DEB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .clr    (clr),
        .onehot (onehot),
        .en     (en),
        .valid  (valid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level flips once the last DEB synchronized samples all disagree with it
    logic [3:0]   m_s1, m_s2, m_deb, m_deb_d, m_press, m_onehot;
    logic         m_en, m_valid, m_err, m_hold;
    logic [255:0] m_hist [4];

    task automatic model_step();
        logic [3:0] pr;
        bit         agree;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_d = '0; m_press = '0;
            m_onehot = '0; m_en = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_hold = 1'b0;
            for (int c = 0; c < 4; c++) m_hist[c] = '0;
        end else begin
            pr      = m_press;
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (clr) begin
                if (m_hold) begin
                    m_hold = 1'b0; m_onehot = '0; m_en = 1'b1;
                end
            end else if ($countones(pr) >= 2) begin
                m_err = 1'b1;
            end else if ($countones(pr) == 1) begin
                m_onehot = pr; m_en = 1'b0; m_valid = 1'b1; m_hold = 1'b1;
            end
            m_press = m_deb & ~m_deb_d;
            m_deb_d = m_deb;
            for (int c = 0; c < 4; c++) begin
                m_hist[c] = {m_hist[c][254:0], m_s2[c]};
                agree = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (m_hist[c][j] == m_deb[c]) agree = 1'b0;
                if (agree) m_deb[c] = ~m_deb[c];
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("model {onehot,en,valid,err}", {28'd0, onehot, en, valid, err},
                {28'd0, m_onehot, m_en, m_valid, m_err});
            if (valid === 1'b1) vcount++;
            if (err === 1'b1) ecount++;
        end
    endtask

    task automatic wait_valid(input int maxc, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step(1);
            if (valid === 1'b1) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic       clr;
        int         cyc;
        logic [3:0] exp_oh;
        logic       exp_en;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 4'b0000, 1'b0,  2, 4'b0000, 1'b1};
        tbl[1] = '{1'b0, 4'b0100, 1'b0, 12, 4'b0100, 1'b0};
        tbl[2] = '{1'b0, 4'b0000, 1'b1,  1, 4'b0000, 1'b1};
        tbl[3] = '{1'b0, 4'b0001, 1'b0, 12, 4'b0001, 1'b0};
        tbl[4] = '{1'b0, 4'b0011, 1'b0, 12, 4'b0010, 1'b0};
        tbl[5] = '{1'b0, 4'b0000, 1'b0, 12, 4'b0010, 1'b0};
        tbl[6] = '{1'b1, 4'b1000, 1'b0,  1, 4'b0000, 1'b1};
        tbl[7] = '{1'b0, 4'b1000, 1'b0, 12, 4'b1000, 1'b0};
        tbl[8] = '{1'b0, 4'b1000, 1'b1,  1, 4'b0000, 1'b1};
        tbl[9] = '{1'b0, 4'b0000, 1'b1,  2, 4'b0000, 1'b1};

        rst = 1'b1; btn = 4'b0000; clr = 1'b0;
        @(negedge clk);
        step(2);
        chk("reset onehot", {28'd0, onehot}, 32'd0);
        chk("reset en", {31'd0, en}, 32'd1);
        chk("reset valid/err", {30'd0, valid, err}, 32'd0);
        rst = 1'b0;

        // Press at edge 10 shows valid exactly after edge 17
        step(7);
        btn = 4'b0010;
        vcount = 0;
        step(7);
        chk("lat no early valid", vcount, 0);
        step(1);
        chk("lat valid edge17", {31'd0, valid}, 32'd1);
        chk("lat onehot", {28'd0, onehot}, 32'h2);
        chk("lat en", {31'd0, en}, 32'd0);
        step(1);
        chk("lat valid one cycle", {31'd0, valid}, 32'd0);

        // New channel while holding, then its release is ignored
        btn = 4'b1010;
        wait_valid(20, "hold press timeout");
        chk("hold onehot", {28'd0, onehot}, 32'h8);
        chk("hold en", {31'd0, en}, 32'd0);
        btn = 4'b0010;
        vcount = 0;
        step(15);
        chk("release no valid", vcount, 0);
        chk("release onehot", {28'd0, onehot}, 32'h8);

        // Bounce on btn[0] never settles long enough
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            step(2);
        end
        btn[0] = 1'b0;
        step(10);
        chk("bounce no valid", vcount, 0);
        chk("bounce onehot", {28'd0, onehot}, 32'h8);

        // Simultaneous presses
        btn = 4'b0000;
        step(10);
        btn = 4'b0110;
        vcount = 0; ecount = 0;
        step(12);
        chk("multi err pulses", ecount, 1);
        chk("multi no valid", vcount, 0);
        chk("multi onehot", {28'd0, onehot}, 32'h8);
        chk("multi en", {31'd0, en}, 32'd0);

        // clr coincident with a single press event in HOLD
        btn = 4'b0000;
        step(10);
        btn = 4'b0001;
        vcount = 0; ecount = 0;
        step(7);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr onehot", {28'd0, onehot}, 32'd0);
        chk("clr en", {31'd0, en}, 32'd1);
        chk("clr valid/err", {30'd0, valid, err}, 32'd0);
        step(5);
        chk("clr no valid after", vcount, 0);
        chk("clr no err", ecount, 0);

        // Reset mid-debounce, button still held afterwards
        btn = 4'b0000;
        step(10);
        btn = 4'b0100;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst outputs", {26'd0, onehot, en, valid, err}, {26'd0, 4'b0000, 1'b1, 1'b0, 1'b0});
        vcount = 0;
        step(7);
        chk("midrst no early valid", vcount, 0);
        step(1);
        chk("midrst valid", {31'd0, valid}, 32'd1);
        chk("midrst onehot", {28'd0, onehot}, 32'h4);
        step(1);
        chk("midrst single valid", vcount, 1);

        // Vector table
        for (int v = 0; v < 10; v++) begin
            rst = tbl[v].rst; btn = tbl[v].btn; clr = tbl[v].clr;
            step(tbl[v].cyc);
            chk($sformatf("vec%0d onehot", v), {28'd0, onehot}, {28'd0, tbl[v].exp_oh});
            chk($sformatf("vec%0d en", v), {31'd0, en}, {31'd0, tbl[v].exp_en});
        end
        rst = 1'b0; clr = 1'b0;

        // Randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            int hold;
            btn  = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) begin
                clr = ($urandom_range(0, 15) == 0);
                rst = ($urandom_range(0, 79) == 0);
                step(1);
            end
        end
        rst = 1'b0; clr = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
